// File: rtl/mem_access_if.sv
// Bundle of execute-side inputs, data-memory request/response and MEM/WB outputs
// for the memory-access stage. clk/rst_n are not carried here.
// Modports: slave = the mem_access stage itself; master = its environment
//   (execute, data memory and writeback together, or a testbench).
interface mem_access_if;
   // execute -> mem_access
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_alu;
   logic [31:0] i_store_data;
   logic [31:0] i_pc4;
   logic [4:0]  i_w_idx;
   logic [1:0]  i_wb_sel;
   logic        i_wb_en;
   logic        i_mem_rd;
   logic        i_mem_wr;
   logic [2:0]  i_funct3;
   // mem_access <-> data memory
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   // mem_access -> writeback
   logic        o_valid;
   logic [31:0] o_mem;
   logic [31:0] o_alu;
   logic [31:0] o_pc4;
   logic [4:0]  o_w_idx;
   logic [1:0]  o_wb_sel;
   logic        o_wb_en;
   logic        o_misalign;

   modport slave (
      input  i_valid, i_alu, i_store_data, i_pc4, i_w_idx, i_wb_sel, i_wb_en,
             i_mem_rd, i_mem_wr, i_funct3, i_dmem_ack, i_dmem_rdata,
      output o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
             o_valid, o_mem, o_alu, o_pc4, o_w_idx, o_wb_sel, o_wb_en, o_misalign
   );

   modport master (
      output i_valid, i_alu, i_store_data, i_pc4, i_w_idx, i_wb_sel, i_wb_en,
             i_mem_rd, i_mem_wr, i_funct3, i_dmem_ack, i_dmem_rdata,
      input  o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
             o_valid, o_mem, o_alu, o_pc4, o_w_idx, o_wb_sel, o_wb_en, o_misalign
   );
endinterface

// File: rtl/mem_access.sv
// Purpose: RISC-V memory-access stage; issues loads/stores over req/ack, aligns and extends load data.
// Latency: non-memory op retires 1 cycle after transfer; memory op retires 1 cycle after dmem ack.
// Backpressure: o_ready low while a memory access is outstanding; no output backpressure (writeback never stalls).
//
// Ports: clk, rst_n (async, active-low) plus mem_access_if.slave carrying the execute
// inputs, the data-memory req/ack bus and the registered MEM/WB outputs.
// Optional feature: define MEM_MISALIGN_TRAP_EN to retire misaligned LH/LHU/SH/LW/SW
// without a memory request, flagged by o_misalign; otherwise o_misalign is always 0
// and misaligned accesses simply drop the low address bits.
module mem_access (
   input  logic        clk,
   input  logic        rst_n,
   mem_access_if.slave bus
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t state, state_nxt;

   // MEM/WB register
   logic        r_valid;
   logic [31:0] r_mem;
   logic [31:0] r_alu;
   logic [31:0] r_pc4;
   logic [4:0]  r_w_idx;
   logic [1:0]  r_wb_sel;
   logic        r_wb_en;
   logic        r_misalign;

   // Request register, held stable for the whole ACCESS state
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic        r_we;
   // Kept for aligning the load data when the ack arrives
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        xfer;
   logic        is_mem;
   logic        trap;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign xfer   = bus.i_valid && (state == IDLE);
   assign is_mem = bus.i_mem_rd || bus.i_mem_wr;

`ifdef MEM_MISALIGN_TRAP_EN
   // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
   // funct3 101 is only a halfword for loads; as a store it is a full-word write.
   always_comb begin
      trap = 1'b0;
      if (is_mem) begin
         case (bus.i_funct3)
            3'b001:  trap = bus.i_alu[0];
            3'b101:  trap = bus.i_alu[0] && !bus.i_mem_wr;
            3'b010:  trap = |bus.i_alu[1:0];
            default: trap = 1'b0;
         endcase
      end
   end
`else
   assign trap = 1'b0;
`endif

   // Byte enables and lane-replicated write data. Stores decode the full funct3;
   // loads only use the size bits so the memory sees a sensible lane mask.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = bus.i_store_data;
      if (bus.i_mem_wr) begin
         case (bus.i_funct3)
            3'b000: begin
               be_nxt    = 4'b0001 << bus.i_alu[1:0];
               wdata_nxt = {4{bus.i_store_data[7:0]}};
            end
            3'b001: begin
               be_nxt    = bus.i_alu[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{bus.i_store_data[15:0]}};
            end
            default: begin
               be_nxt    = 4'b1111;
               wdata_nxt = bus.i_store_data;
            end
         endcase
      end else begin
         case (bus.i_funct3[1:0])
            2'b00:   be_nxt = 4'b0001 << bus.i_alu[1:0];
            2'b01:   be_nxt = bus.i_alu[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
         endcase
      end
   end

   // Load alignment and extension from the returned word
   always_comb begin
      case (r_off)
         2'd0:    ld_byte = bus.i_dmem_rdata[7:0];
         2'd1:    ld_byte = bus.i_dmem_rdata[15:8];
         2'd2:    ld_byte = bus.i_dmem_rdata[23:16];
         default: ld_byte = bus.i_dmem_rdata[31:24];
      endcase
      ld_half = r_off[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];
      case (r_funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = bus.i_dmem_rdata;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state and handshake outputs. o_dmem_req comes straight from the
   // state register, so an asynchronous reset drops it immediately.
   always_comb begin
      state_nxt      = state;
      bus.o_ready    = 1'b0;
      bus.o_dmem_req = 1'b0;
      case (state)
         IDLE: begin
            bus.o_ready = 1'b1;
            if (xfer && is_mem && !trap) state_nxt = ACCESS;
         end
         ACCESS: begin
            bus.o_dmem_req = 1'b1;
            if (bus.i_dmem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: MEM/WB and request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_mem      <= '0;
         r_alu      <= '0;
         r_pc4      <= '0;
         r_w_idx    <= '0;
         r_wb_sel   <= '0;
         r_wb_en    <= 1'b0;
         r_misalign <= 1'b0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_funct3   <= '0;
         r_off      <= '0;
      end else begin
         // o_valid and o_misalign are single-cycle pulses
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer) begin
                  r_alu    <= bus.i_alu;
                  r_pc4    <= bus.i_pc4;
                  r_w_idx  <= bus.i_w_idx;
                  r_wb_sel <= bus.i_wb_sel;
                  r_mem    <= '0;
                  if (is_mem && !trap) begin
                     r_wb_en  <= bus.i_wb_en;
                     r_addr   <= {bus.i_alu[31:2], 2'b00};
                     r_be     <= be_nxt;
                     r_wdata  <= wdata_nxt;
                     // a store wins when both read and write are flagged
                     r_we     <= bus.i_mem_wr;
                     r_funct3 <= bus.i_funct3;
                     r_off    <= bus.i_alu[1:0];
                  end else begin
                     // plain ALU op, or a trapped misaligned access
                     r_valid    <= 1'b1;
                     r_wb_en    <= bus.i_wb_en && !trap;
                     r_misalign <= trap;
                  end
               end
            end
            ACCESS: begin
               if (bus.i_dmem_ack) begin
                  r_valid <= 1'b1;
                  r_mem   <= r_we ? 32'd0 : ld_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_dmem_we    = r_we;
   assign bus.o_dmem_addr  = r_addr;
   assign bus.o_dmem_be    = r_be;
   assign bus.o_dmem_wdata = r_wdata;

   assign bus.o_valid    = r_valid;
   assign bus.o_mem      = r_mem;
   assign bus.o_alu      = r_alu;
   assign bus.o_pc4      = r_pc4;
   assign bus.o_w_idx    = r_w_idx;
   assign bus.o_wb_sel   = r_wb_sel;
   assign bus.o_wb_en    = r_valid && r_wb_en;
   assign bus.o_misalign = r_misalign;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed instructions, a queue of expected retirements computed
// from the architectural load/store rules, and one per-cycle compare process.
// Define MEM_MISALIGN_TRAP_EN on both bench and RTL to exercise the trapping variant.
module tb_mem_access;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   run = 0;

   mem_access_if bus ();

   mem_access dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] mem;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [4:0]  w_idx;
      logic [1:0]  wb_sel;
      logic        wb_en;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];

   // expected outstanding request
   logic        exp_req = 1'b0;
   logic [31:0] exp_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wdata;
   logic        exp_we;
   // last request seen on the bus, for literal checks
   logic [31:0] seen_addr = '0;
   logic [3:0]  seen_be = '0;
   logic [31:0] seen_wdata = '0;
   logic        seen_we = 1'b0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic logic [31:0] load_model(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * (a % 4))) & 32'hFF;
      h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] be_model(logic [2:0] f3, logic [31:0] a);
      if (f3 == 3'd0) return 4'(1 << (a % 4));
      if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] wdata_model(logic [2:0] f3, logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic mis_model(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      if (!(rd || wr)) return 1'b0;
      if (f3 == 3'd1 || (f3 == 3'd5 && !wr)) return (a % 2) != 0;
      if (f3 == 3'd2) return (a % 4) != 0;
`endif
      return 1'b0;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (run) begin
         if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(bus.o_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("retire_cycle", cyc, e.cyc);
               chk("o_mem", bus.o_mem, e.mem);
               chk("o_alu", bus.o_alu, e.alu);
               chk("o_pc4", bus.o_pc4, e.pc4);
               chk("o_w_idx", 32'(bus.o_w_idx), 32'(e.w_idx));
               chk("o_wb_sel", 32'(bus.o_wb_sel), 32'(e.wb_sel));
               chk("o_wb_en", 32'(bus.o_wb_en), 32'(e.wb_en));
               chk("o_misalign", 32'(bus.o_misalign), 32'(e.mis));
            end
         end else begin
            chk("wb_en_idle", 32'(bus.o_wb_en), 32'd0);
            chk("misalign_idle", 32'(bus.o_misalign), 32'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               chk("missing_valid", 32'(bus.o_valid), 32'd1);
               void'(exp_q.pop_front());
            end
         end
         chk("o_dmem_req", 32'(bus.o_dmem_req), 32'(exp_req));
         chk("o_ready", 32'(bus.o_ready), 32'(!exp_req));
         if (exp_req && bus.o_dmem_req) begin
            chk("o_dmem_addr", bus.o_dmem_addr, exp_addr);
            chk("o_dmem_we", 32'(bus.o_dmem_we), 32'(exp_we));
            if (exp_we) begin
               chk("o_dmem_be", 32'(bus.o_dmem_be), 32'(exp_be));
               chk("o_dmem_wdata", bus.o_dmem_wdata, exp_wdata);
            end
         end
         if (bus.o_dmem_req) begin
            seen_addr  = bus.o_dmem_addr;
            seen_be    = bus.o_dmem_be;
            seen_wdata = bus.o_dmem_wdata;
            seen_we    = bus.o_dmem_we;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.o_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.o_ready) chk("ready_timeout", 32'(bus.o_ready), 32'd1);
   endtask

   task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] idx,
                     input logic en, input int k, input logic [31:0] rdata);
      exp_t e;
      logic mis;
      wait_ready();
      bus.i_valid      = 1'b1;
      bus.i_alu        = alu;
      bus.i_store_data = sd;
      bus.i_pc4        = pc_ctr;
      bus.i_w_idx      = idx;
      bus.i_wb_sel     = pc_ctr[3:2];
      bus.i_wb_en      = en;
      bus.i_mem_rd     = rd;
      bus.i_mem_wr     = wr;
      bus.i_funct3     = f3;
      @(posedge clk); #1;
      bus.i_valid  = 1'b0;
      bus.i_mem_rd = 1'b0;
      bus.i_mem_wr = 1'b0;
      mis      = mis_model(rd, wr, f3, alu);
      e.alu    = alu;
      e.pc4    = pc_ctr;
      e.w_idx  = idx;
      e.wb_sel = pc_ctr[3:2];
      e.mis    = mis;
      e.wb_en  = en && !mis;
      e.mem    = 32'd0;
      pc_ctr   = pc_ctr + 4;
      if (!(rd || wr) || mis) begin
         e.cyc = cyc;
         exp_q.push_back(e);
      end else begin
         exp_req   = 1'b1;
         exp_addr  = alu - (alu % 4);
         exp_we    = wr;
         exp_be    = be_model(f3, alu);
         exp_wdata = wdata_model(f3, sd);
         repeat (k) begin
            @(posedge clk); #1;
         end
         bus.i_dmem_ack   = 1'b1;
         bus.i_dmem_rdata = rdata;
         @(posedge clk); #1;
         bus.i_dmem_ack   = 1'b0;
         bus.i_dmem_rdata = 32'hDEAD_BEEF;
         exp_req = 1'b0;
         if (!wr) e.mem = load_model(f3, alu, rdata);
         e.cyc = cyc;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      rst_n            = 1'b1;
      bus.i_valid      = 1'b0;
      bus.i_alu        = '0;
      bus.i_store_data = '0;
      bus.i_pc4        = '0;
      bus.i_w_idx      = '0;
      bus.i_wb_sel     = '0;
      bus.i_wb_en      = 1'b0;
      bus.i_mem_rd     = 1'b0;
      bus.i_mem_wr     = 1'b0;
      bus.i_funct3     = '0;
      bus.i_dmem_ack   = 1'b0;
      bus.i_dmem_rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_o_dmem_req", 32'(bus.o_dmem_req), 32'd0);
      chk("rst_o_mem", bus.o_mem, 32'd0);
      chk("rst_o_alu", bus.o_alu, 32'd0);
      chk("rst_o_dmem_addr", bus.o_dmem_addr, 32'd0);
      chk("rst_o_dmem_be", 32'(bus.o_dmem_be), 32'd0);
      chk("rst_o_wb_en", 32'(bus.o_wb_en), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run = 1;
      @(posedge clk); #1;

      // ALU op
      op(0, 0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 32'd0);
      @(negedge clk);
      chk("alu_valid", 32'(bus.o_valid), 32'd1);
      chk("alu_o_alu", bus.o_alu, 32'h0000_1234);
      chk("alu_w_idx", 32'(bus.o_w_idx), 32'd5);
      chk("alu_wb_en", 32'(bus.o_wb_en), 32'd1);
      @(posedge clk); #1;

      // back-to-back ALU ops, one per cycle
      op(0, 0, 3'd0, 32'h0000_0001, 32'd0, 5'd1, 1, 0, 32'd0);
      op(0, 0, 3'd2, 32'h0000_0002, 32'd0, 5'd2, 0, 0, 32'd0);
      op(0, 0, 3'd7, 32'hFFFF_FFFF, 32'd0, 5'd31, 1, 0, 32'd0);

      // LB 0x103, ack 3 cycles after req
      op(1, 0, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 1, 3, 32'h80AA_BBCC);
      @(negedge clk);
      chk("lb_o_mem", bus.o_mem, 32'hFFFF_FF80);
      chk("lb_valid", 32'(bus.o_valid), 32'd1);
      @(posedge clk); #1;

      // LHU 0x102, immediate ack
      op(1, 0, 3'd5, 32'h0000_0102, 32'd0, 5'd8, 1, 0, 32'hBEEF_1234);
      @(negedge clk);
      chk("lhu_o_mem", bus.o_mem, 32'h0000_BEEF);
      chk("lhu_addr", seen_addr, 32'h0000_0100);
      @(posedge clk); #1;

      // SB 0x201, data 0x5A
      op(0, 1, 3'd0, 32'h0000_0201, 32'h0000_005A, 5'd0, 0, 1, 32'd0);
      @(negedge clk);
      chk("sb_be", 32'(seen_be), 32'h2);
      chk("sb_wdata", seen_wdata, 32'h5A5A_5A5A);
      chk("sb_we", 32'(seen_we), 32'd1);
      chk("sb_wb_en", 32'(bus.o_wb_en), 32'd0);
      chk("sb_o_mem", bus.o_mem, 32'd0);
      @(posedge clk); #1;

      // more load/store shapes
      op(1, 0, 3'd1, 32'h0000_0206, 32'd0, 5'd9, 1, 2, 32'h8001_7FFF);
      @(negedge clk);
      chk("lh_o_mem", bus.o_mem, 32'hFFFF_8001);
      @(posedge clk); #1;
      op(1, 0, 3'd4, 32'h0000_0101, 32'd0, 5'd10, 1, 1, 32'h0000_80FF);
      op(1, 0, 3'd2, 32'h0000_0104, 32'd0, 5'd11, 1, 0, 32'hCAFE_F00D);
      op(0, 1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 0, 0, 32'd0);
      @(negedge clk);
      chk("sh_be", 32'(seen_be), 32'hC);
      chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
      @(posedge clk); #1;
      op(0, 1, 3'd2, 32'h0000_0208, 32'h0102_0304, 5'd0, 0, 2, 32'd0);
      // read and write both set: store, o_mem 0
      op(1, 1, 3'd2, 32'h0000_020C, 32'h7777_8888, 5'd12, 0, 0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("rdwr_we", 32'(seen_we), 32'd1);
      chk("rdwr_o_mem", bus.o_mem, 32'd0);
      @(posedge clk); #1;

      // misaligned LW 0x102
      op(1, 0, 3'd2, 32'h0000_0102, 32'd0, 5'd13, 1, 1, 32'h1111_2222);
`ifdef MEM_MISALIGN_TRAP_EN
      @(negedge clk);
      chk("mis_valid", 32'(bus.o_valid), 32'd1);
      chk("mis_flag", 32'(bus.o_misalign), 32'd1);
      chk("mis_wb_en", 32'(bus.o_wb_en), 32'd0);
`else
      @(negedge clk);
      chk("mis_addr", seen_addr, 32'h0000_0100);
      chk("mis_o_mem", bus.o_mem, 32'h1111_2222);
`endif
      @(posedge clk); #1;

      // ack while idle is ignored
      bus.i_dmem_ack = 1'b1;
      @(posedge clk); #1;
      bus.i_dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_valid", 32'(bus.o_valid), 32'd0);
      @(posedge clk); #1;

      // reset in the middle of an access, then a stray ack
      wait_ready();
      bus.i_valid  = 1'b1;
      bus.i_alu    = 32'h0000_0300;
      bus.i_mem_rd = 1'b1;
      bus.i_funct3 = 3'd2;
      bus.i_wb_en  = 1'b1;
      @(posedge clk); #1;
      bus.i_valid  = 1'b0;
      bus.i_mem_rd = 1'b0;
      exp_req  = 1'b1;
      exp_addr = 32'h0000_0300;
      exp_we   = 1'b0;
      @(posedge clk); #2;
      rst_n   = 1'b0;
      exp_req = 1'b0;
      #1;
      chk("rst_req_async", 32'(bus.o_dmem_req), 32'd0);
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.i_dmem_ack   = 1'b1;
      bus.i_dmem_rdata = 32'h5555_5555;
      @(posedge clk); #1;
      bus.i_dmem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_valid", 32'(bus.o_valid), 32'd0);
      chk("stray_ack_req", 32'(bus.o_dmem_req), 32'd0);

      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      run = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V core, directly upstream of writeback. It accepts one instruction at a time from execute and issues loads and stores to data memory over a req/ack handshake. Load data is aligned and sign/zero-extended here. Its registered MEM/WB outputs feed writeback's `i_mem`, `i_alu`, `i_pc4`, `i_w_idx`, `i_wb_sel` and `i_wb_en` unchanged.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: execute presents an instruction.
- `o_ready` out 1: stage can accept; instruction transfers when `i_valid && o_ready`.
- `i_alu` in 32: ALU result / effective address.
- `i_store_data` in 32: rs2 value for stores.
- `i_pc4` in 32: PC+4.
- `i_w_idx` in 5: destination register.
- `i_wb_sel` in 2: writeback source select, passed through.
- `i_wb_en` in 1: register write enable, passed through.
- `i_mem_rd` in 1: instruction is a load.
- `i_mem_wr` in 1: instruction is a store.
- `i_funct3` in 3: access size/sign.
- `o_dmem_req` out 1: memory request.
- `o_dmem_we` out 1: 1 = write.
- `o_dmem_addr` out 32: word address, bits [1:0] = 0.
- `o_dmem_be` out 4: byte enables.
- `o_dmem_wdata` out 32: lane-replicated store data.
- `i_dmem_ack` in 1: request complete; `i_dmem_rdata` valid this cycle.
- `i_dmem_rdata` in 32: read word.
- `o_valid` out 1: one-cycle pulse, MEM/WB register holds a retiring instruction.
- `o_mem`, `o_alu`, `o_pc4` out 32 each: to writeback.
- `o_w_idx` out 5, `o_wb_sel` out 2, `o_wb_en` out 1: to writeback. `o_wb_en` is gated: it equals registered `i_wb_en` only while `o_valid` = 1, otherwise 0.
- `o_misalign` out 1: misaligned access flag (see Configuration).

## Operation
- FSM states:
  - IDLE: `o_ready` = 1.
  - ACCESS: `o_ready` = 0, `o_dmem_req` = 1.
- IDLE, transfer, no memory op: payload is registered to MEM/WB and `o_valid` = 1 next cycle. State stays IDLE.
- IDLE, transfer, memory op: payload, address, be, wdata and we are registered. Next state is ACCESS.
- ACCESS: request fields are held stable until `i_dmem_ack`. On ack:
  - load data is aligned into `o_mem`;
  - `o_valid` pulses the following cycle;
  - state returns to IDLE.
- `i_mem_rd` and `i_mem_wr` both set: store performed, read ignored.
- Store `o_dmem_be` / `o_dmem_wdata`:
  - funct3 000 (SB): be = 1<<addr[1:0], data byte replicated ×4.
  - funct3 001 (SH): be = addr[1] ? 1100 : 0011, halfword replicated ×2.
  - funct3 010 (SW) and any other funct3: be = 1111.
- Load extraction: byte selected by addr[1:0], half by addr[1].
  - 000 (LB): sign-extend byte. 100 (LBU): zero-extend byte.
  - 001 (LH): sign-extend half. 101 (LHU): zero-extend half.
  - Others: full word.
- For stores, `o_mem` is 0.
- `i_dmem_ack` in IDLE is ignored.
- Reset mid-ACCESS: request drops immediately. A late ack after reset is ignored.

## Timing
- Reset values:
  - all outputs 0, except `o_ready` = 1;
  - FSM in IDLE.
- Non-memory latency: transfer at T, `o_valid` at T+1.
- Memory latency: transfer at T, `o_dmem_req` high from T+1. With ack at T+1+k (k ≥ 0), `o_valid` is at T+2+k and `o_ready` is high again at T+2+k.
- Back-to-back non-memory instructions: throughput 1 per cycle.
- Writeback never stalls, so there is no output backpressure.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0, issue no memory request.
  - The instruction retires as a non-memory op (`o_valid` at T+1) with `o_misalign` = 1 and `o_wb_en` = 0.
  - `o_misalign` pulses only alongside `o_valid`.
- Undefined:
  - `o_misalign` tied 0.
  - Misaligned accesses proceed with the low address bits ignored beyond the access size: word accesses use `o_dmem_addr` = addr & ~3; halfword accesses use addr[1] only.

## Test plan
- ALU op `i_alu`=0x1234, `i_wb_en`=1, `i_w_idx`=5 -> `o_valid` next cycle, `o_alu`=0x1234, `o_w_idx`=5, `o_wb_en`=1; `o_dmem_req` never asserted.
- LB addr 0x103, ack 3 cycles after req, rdata 0x80AABBCC -> `o_mem`=0xFFFFFF80, `o_valid` cycle after ack, `o_ready`=0 throughout ACCESS.
- LHU addr 0x102, immediate ack, rdata 0xBEEF1234 -> `o_mem`=0x0000BEEF, `o_dmem_addr`=0x100.
- SB addr 0x201, data 0x5A -> `o_dmem_be`=0010, `o_dmem_wdata`=0x5A5A5A5A, `o_dmem_we`=1, `o_wb_en`=0 at retire.
- Assert `rst_n`=0 mid-ACCESS, then ack after release -> req drops asynchronously, stray ack ignored, no `o_valid`.
- With `MEM_MISALIGN_TRAP_EN`, LW addr 0x102 -> no request, `o_valid` and `o_misalign` at T+1, `o_wb_en`=0; without macro -> request to 0x100.
